// File: rtl/lcd_serial_writer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lcd_serial_writer_if                                             |
// | Purpose : Bundles the segment-image request side and the 3-wire LCD bus    |
// |           of lcd_serial_writer.                                            |
// | Signals : data_in[71:0] segment image (bit i*9+k = segment k of char i)    |
// |           update        single-cycle write request                         |
// |           busy          frame in progress or pending                       |
// |           done          one-cycle pulse at end of a write frame            |
// |           lcd_cs_n      chip select, active-low                            |
// |           lcd_wr_n      write strobe, data latched on rising edge          |
// |           lcd_data      serial data                                        |
// | Modports: master (drives requests), slave (the writer itself)              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface lcd_serial_writer_if;
  logic [71:0] data_in;
  logic        update;
  logic        busy;
  logic        done;
  logic        lcd_cs_n;
  logic        lcd_wr_n;
  logic        lcd_data;

  modport master (
    output data_in, update,
    input  busy, done, lcd_cs_n, lcd_wr_n, lcd_data
  );

  modport slave (
    input  data_in, update,
    output busy, done, lcd_cs_n, lcd_wr_n, lcd_data
  );
endinterface
`default_nettype wire

// File: rtl/lcd_serial_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lcd_serial_writer                                                |
// | Purpose : Serialises a 72-bit segment image to an HT1621-style LCD         |
// |           controller. After reset sends SYS_EN, LCD_ON and CMD_BIAS        |
// |           command frames, then one 81-bit RAM write frame per request.     |
// | Ports   : clk  system clock                                                |
// |           rst  asynchronous active-high reset                              |
// |           bus  lcd_serial_writer_if.slave (request side + 3-wire bus)      |
// | Params  : CLK_DIV  clk cycles per WR_n half-period (1..255)                |
// |           CMD_BIAS bias/com configuration command byte                     |
// | Macro   : LCD_AUTO_UPDATE_EN - when defined, a change of data_in versus    |
// |           the last transmitted image acts as an update request in IDLE.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module lcd_serial_writer #(
  parameter int         CLK_DIV  = 25,
  parameter logic [7:0] CMD_BIAS = 8'h29
) (
  input  wire logic           clk,
  input  wire logic           rst,
  lcd_serial_writer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_CMD   = 3'd1,
    S_GAP   = 3'd2,
    S_IDLE  = 3'd3,
    S_LOAD  = 3'd4,
    S_SHIFT = 3'd5
  } state_t;

  // Sub-phases of a frame while CS_n is low.
  typedef enum logic [1:0] {
    P_SETUP = 2'd0,  // CS_n low, WR_n high, first bit on the line
    P_LOW   = 2'd1,
    P_HIGH  = 2'd2,
    P_TAIL  = 2'd3   // one extra cycle before CS_n rises
  } phase_t;

  localparam logic [8:0] c_DIV_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] c_GAP_LAST = 9'(2 * CLK_DIV - 1);
  localparam logic [6:0] c_CMD_BITS = 7'd12;
  localparam logic [6:0] c_WR_BITS  = 7'd81;

  state_t      r_state, w_state_nxt;
  phase_t      r_ph, w_ph_nxt;
  logic [8:0]  r_cnt, w_cnt_nxt;
  logic [6:0]  r_bits, w_bits_nxt;
  logic [1:0]  r_cmd_idx, w_cmd_idx_nxt;
  logic [80:0] r_sh, w_sh_nxt;
  logic        r_pending, w_pending_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        r_cs_n, w_cs_n_nxt;
  logic        r_wr_n, w_wr_n_nxt;
  logic        r_data, w_data_nxt;
  logic        w_pending_clr;
  logic        w_req;

  // Command frame left-aligned in the 81-bit shifter: ID 100, byte, 0.
  function automatic logic [80:0] cmd_frame(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'h01;
      2'd1:    b = 8'h03;
      default: b = CMD_BIAS;
    endcase
    return {3'b100, b, 1'b0, 69'd0};
  endfunction

  // Write frame: ID 101, address 0, then data_in[0] first.
  function automatic logic [80:0] write_frame(input logic [71:0] d);
    logic [71:0] rev;
    for (int i = 0; i < 72; i++) rev[71-i] = d[i];
    return {3'b101, 6'd0, rev};
  endfunction

`ifdef LCD_AUTO_UPDATE_EN
  logic [71:0] r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_last <= '0;
    else if (r_state == S_LOAD) r_last <= bus.data_in;
  end

  assign w_req = bus.update | (bus.data_in != r_last);
`else
  assign w_req = bus.update;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_INIT;
      r_ph      <= P_SETUP;
      r_cnt     <= '0;
      r_bits    <= '0;
      r_cmd_idx <= '0;
      r_sh      <= '0;
      r_pending <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_wr_n    <= 1'b1;
      r_data    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ph      <= w_ph_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bits    <= w_bits_nxt;
      r_cmd_idx <= w_cmd_idx_nxt;
      r_sh      <= w_sh_nxt;
      r_pending <= w_pending_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_wr_n    <= w_wr_n_nxt;
      r_data    <= w_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ph_nxt      = r_ph;
    w_cnt_nxt     = r_cnt;
    w_bits_nxt    = r_bits;
    w_cmd_idx_nxt = r_cmd_idx;
    w_sh_nxt      = r_sh;
    w_cs_n_nxt    = r_cs_n;
    w_wr_n_nxt    = r_wr_n;
    w_data_nxt    = r_data;
    w_done_nxt    = 1'b0;
    w_pending_clr = 1'b0;

    case (r_state)
      S_INIT: begin
        w_state_nxt   = S_CMD;
        w_cmd_idx_nxt = 2'd0;
        w_sh_nxt      = cmd_frame(2'd0);
        w_data_nxt    = w_sh_nxt[80];
        w_cs_n_nxt    = 1'b0;
        w_wr_n_nxt    = 1'b1;
        w_ph_nxt      = P_SETUP;
        w_cnt_nxt     = '0;
        w_bits_nxt    = c_CMD_BITS;
      end

      S_CMD, S_SHIFT: begin
        w_cnt_nxt = r_cnt + 9'd1;
        case (r_ph)
          P_SETUP: begin
            if (r_cnt == c_DIV_LAST) begin
              w_ph_nxt   = P_LOW;
              w_wr_n_nxt = 1'b0;
              w_cnt_nxt  = '0;
            end
          end
          P_LOW: begin
            // The next bit is put on the line together with the WR_n
            // rising edge, so it is stable for the whole following
            // high phase and the next low phase.
            if (r_cnt == c_DIV_LAST) begin
              w_ph_nxt   = P_HIGH;
              w_wr_n_nxt = 1'b1;
              w_cnt_nxt  = '0;
              w_sh_nxt   = {r_sh[79:0], 1'b0};
              w_data_nxt = r_sh[79];
              w_bits_nxt = r_bits - 7'd1;
            end
          end
          P_HIGH: begin
            if (r_cnt == c_DIV_LAST) begin
              w_cnt_nxt = '0;
              if (r_bits == 7'd0) begin
                w_ph_nxt = P_TAIL;
              end else begin
                w_ph_nxt   = P_LOW;
                w_wr_n_nxt = 1'b0;
              end
            end
          end
          default: begin
            w_state_nxt = S_GAP;
            w_cs_n_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            w_done_nxt  = (r_state == S_SHIFT);
          end
        endcase
      end

      S_GAP: begin
        w_cnt_nxt = r_cnt + 9'd1;
        if (r_cnt == c_GAP_LAST) begin
          w_cnt_nxt = '0;
          // The command index stays at 2 once init is done, so any later
          // gap belongs to a write frame.
          if (r_cmd_idx != 2'd2) begin
            w_state_nxt   = S_CMD;
            w_cmd_idx_nxt = 2'(r_cmd_idx + 2'd1);
            w_sh_nxt      = cmd_frame(w_cmd_idx_nxt);
            w_data_nxt    = w_sh_nxt[80];
            w_cs_n_nxt    = 1'b0;
            w_wr_n_nxt    = 1'b1;
            w_ph_nxt      = P_SETUP;
            w_bits_nxt    = c_CMD_BITS;
          end else if (r_pending) begin
            w_state_nxt   = S_LOAD;
            w_pending_clr = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      S_IDLE: begin
        if (w_req || r_pending) begin
          w_state_nxt   = S_LOAD;
          w_pending_clr = 1'b1;
        end
      end

      S_LOAD: begin
        w_state_nxt = S_SHIFT;
        w_sh_nxt    = write_frame(bus.data_in);
        w_data_nxt  = w_sh_nxt[80];
        w_cs_n_nxt  = 1'b0;
        w_wr_n_nxt  = 1'b1;
        w_ph_nxt    = P_SETUP;
        w_cnt_nxt   = '0;
        w_bits_nxt  = c_WR_BITS;
      end

      default: begin
        w_state_nxt = S_INIT;
      end
    endcase

    // A new request wins over a same-cycle clear so it is never lost.
    if (bus.update && (r_state != S_IDLE)) w_pending_nxt = 1'b1;
    else if (w_pending_clr)                w_pending_nxt = 1'b0;
    else                                   w_pending_nxt = r_pending;

    w_busy_nxt = (w_state_nxt != S_IDLE) | w_pending_nxt;
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.lcd_cs_n = r_cs_n;
  assign bus.lcd_wr_n = r_wr_n;
  assign bus.lcd_data = r_data;

endmodule
`default_nettype wire
